// File: rtl/line_buffer_3row.sv
// 3-row line buffer: turns a raster pixel stream into vertically aligned (r-2, r-1, r) columns.
// Optional top-border zero padding is enabled with `define LB_ZERO_PAD_EN.
module line_buffer_3row #(
    parameter int BIT_DEPTH  = 8,
    parameter int IMG_WIDTH  = 8,
    parameter int IMG_HEIGHT = 8,
    parameter int COL_W      = $clog2(IMG_WIDTH),
    parameter int ROW_W      = $clog2(IMG_HEIGHT)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [BIT_DEPTH-1:0] pix_in,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [BIT_DEPTH-1:0] out1,
    output logic [BIT_DEPTH-1:0] out2,
    output logic [BIT_DEPTH-1:0] out3,
    output logic [COL_W-1:0]     out_col,
    output logic                 out_last_col,
    output logic                 out_last,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 state_dbg
);

    // Handshake: a pixel moves on in_valid && in_ready, a column on out_valid && out_ready,
    // both at the rising edge; a stalled output holds every out* field stable.

    typedef enum logic {
        FILL   = 1'b0,
        STREAM = 1'b1
    } state_t;

    localparam logic [COL_W-1:0] COL_MAX = COL_W'(IMG_WIDTH - 1);
    localparam logic [ROW_W-1:0] ROW_MAX = COL_W > 0 ? ROW_W'(IMG_HEIGHT - 1) : '0;
    localparam logic [ROW_W-1:0] ROW_ONE = ROW_W'(1);

    state_t               state_q, state_d;
    logic [COL_W-1:0]     col_q;
    logic [ROW_W-1:0]     row_q;
    logic [BIT_DEPTH-1:0] row_a [IMG_WIDTH];
    logic [BIT_DEPTH-1:0] row_b [IMG_WIDTH];
    logic [BIT_DEPTH-1:0] rd_a, rd_b;
    logic [BIT_DEPTH-1:0] col_top, col_mid;
    logic                 accept, emit, out_free, col_last, row_last;

    assign col_last  = (col_q == COL_MAX);
    assign row_last  = (row_q == ROW_MAX);
    assign out_free  = !out_valid || out_ready;
    assign rd_a      = row_a[col_q];
    assign rd_b      = row_b[col_q];
    assign state_dbg = state_q;

`ifdef LB_ZERO_PAD_EN
    // Rows above the image top read as zero instead of stale memory contents.
    assign col_top = (row_q < ROW_W'(2)) ? '0 : rd_a;
    assign col_mid = (row_q == '0) ? '0 : rd_b;
`else
    assign col_top = rd_a;
    assign col_mid = rd_b;
`endif

    always_comb begin
        state_d  = state_q;
        in_ready = 1'b1;
        emit     = 1'b0;
`ifdef LB_ZERO_PAD_EN
        in_ready = out_free;
        accept   = in_valid && in_ready;
        emit     = accept;
`else
        in_ready = (state_q == FILL) ? 1'b1 : out_free;
        accept   = in_valid && in_ready;
        emit     = accept && (state_q == STREAM);
`endif
        if (accept && col_last) begin
            if (row_last) begin
                state_d = FILL;
            end else if (row_q == ROW_ONE) begin
                state_d = STREAM;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= FILL;
            col_q   <= '0;
            row_q   <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                if (col_last) begin
                    col_q <= '0;
                    row_q <= row_last ? '0 : row_q + ROW_W'(1);
                end else begin
                    col_q <= col_q + COL_W'(1);
                end
            end
        end
    end

    // Row memories carry no reset; stale contents are never emitted unmasked.
    always_ff @(posedge clk) begin
        if (accept) begin
            row_a[col_q] <= rd_b;
            row_b[col_q] <= pix_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out1         <= '0;
            out2         <= '0;
            out3         <= '0;
            out_col      <= '0;
            out_last_col <= 1'b0;
            out_last     <= 1'b0;
            out_valid    <= 1'b0;
        end else if (emit) begin
            out1         <= col_top;
            out2         <= col_mid;
            out3         <= pix_in;
            out_col      <= col_q;
            out_last_col <= col_last;
            out_last     <= col_last && row_last;
            out_valid    <= 1'b1;
        end else if (out_valid && out_ready) begin
            out_valid    <= 1'b0;
        end
    end

endmodule

// File: doc/line_buffer_3row.md
Name: line_buffer_3row

Overview:
Upstream neighbour of the kernel register in the NPU conv datapath. Takes a raster-order pixel stream. Holds the two previous image rows in on-chip row memories. For every accepted pixel, emits one vertically aligned 3-pixel column (rows r-2, r-1, r) that feeds the kernel register's in1/in2/in3 inputs. Valid/ready handshakes on both sides; output is a single registered stage.

Parameters:
BIT_DEPTH, 8, pixel width in bits
IMG_WIDTH, 8, pixels per row, must be >= 2
IMG_HEIGHT, 8, rows per frame, must be >= 3
COL_W, $clog2(IMG_WIDTH), column counter width (derived)
ROW_W, $clog2(IMG_HEIGHT), row counter width (derived)

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous active-high reset
pix_in  in  BIT_DEPTH  input pixel, raster order
in_valid  in  1  pix_in valid
in_ready  out  1  block can accept pix_in this cycle
out1  out  BIT_DEPTH  pixel from row r-2 (oldest), same column
out2  out  BIT_DEPTH  pixel from row r-1, same column
out3  out  BIT_DEPTH  pixel from row r (current)
out_col  out  COL_W  column index of the emitted column
out_last_col  out  1  emitted column is column IMG_WIDTH-1
out_last  out  1  emitted column is the final column of the frame
out_valid  out  1  out* valid
out_ready  in  1  downstream accepts out* this cycle

Behaviour:
- Accept = in_valid && in_ready. Output handshake = out_valid && out_ready.
- Storage: two row memories row_a (r-2) and row_b (r-1), IMG_WIDTH entries each. Memories are not reset.
- Counters col (0..IMG_WIDTH-1) and row (0..IMG_HEIGHT-1) advance on every accept.
  - col wraps to 0 after IMG_WIDTH-1, then row increments.
  - After (IMG_HEIGHT-1, IMG_WIDTH-1): row and col both go to 0 and the state returns to FILL.
- On accept at column c:
  - row_a[c] <= row_b[c] and row_b[c] <= pix_in.
  - If a column is emitted: out1 <= old row_a[c], out2 <= old row_b[c], out3 <= pix_in.
- State FILL (reset state, row < 2):
  - in_ready = 1.
  - Accepts write the memories only; no column is emitted.
  - Entering row 2 moves the state to STREAM.
- State STREAM (row >= 2):
  - in_ready = !out_valid || out_ready.
  - Each accept registers a column and sets out_valid the next cycle. Latency is 1 cycle from accept to out_valid.
  - out_col = c. out_last_col = (c == IMG_WIDTH-1). out_last = out_last_col && row == IMG_HEIGHT-1.
- Handshake rules:
  - While out_valid && !out_ready: all out* hold stable and no pixel is accepted.
  - Output handshake with no accept in the same cycle: out_valid <= 0.
  - Output handshake and accept in the same cycle: new column loaded, full throughput of 1 column/cycle.
- Frame boundary: the first two rows of each frame produce no output. The final column (out_last=1) is emitted even though the state is already FILL. Data from the previous frame is never emitted.
- Reset values:
  - out1/out2/out3 = 0, out_col = 0, out_last_col = 0, out_last = 0, out_valid = 0.
  - col = 0, row = 0, state = FILL, in_ready = 1.
- Reset mid-frame discards the pending output and all position state. The next accepted pixel is treated as (row 0, col 0).
- No combinational path from pix_in to out*. in_ready depends only on out_valid, out_ready and state.

Optional Feature:
Macro LB_ZERO_PAD_EN.
- Defined:
  - Top-border zero padding; FILL emits too. Every accept emits a column.
  - out1 forced 0 when row < 2; out2 forced 0 when row == 0.
  - In FILL, in_ready follows the STREAM rule.
  - A frame yields IMG_HEIGHT*IMG_WIDTH columns.
- Undefined: behaviour exactly as above; a frame yields (IMG_HEIGHT-2)*IMG_WIDTH columns and no masking logic exists.

Test Plan:
- Reset check: rst=1 for 2 cycles -> out_valid=0, out1..3=0, out_col=0, in_ready=1.
- Full stream with IMG_WIDTH=4, IMG_HEIGHT=4, pixel=row*16+col, out_ready=1:
  - No out_valid during the first 8 accepts.
  - Cycle after accepting 0x20 -> out1=0x00, out2=0x10, out3=0x20, out_col=0.
  - Exactly 8 columns total. Last column is out1=0x13, out2=0x23, out3=0x33, out_last_col=1, out_last=1.
- Backpressure: hold out_ready=0 while column (0x01,0x11,0x21) is valid, for 5 cycles -> outputs stable, in_ready=0, pix 0x22 not consumed. Release -> 0x22 column follows with no loss or duplication.
- Frame wrap: second frame with pixels 0x80+row*16+col back-to-back -> first column of frame 2 is (0x80,0x90,0xA0). No frame-1 value appears.
- Reset mid-frame: assert rst after accepting 0x22 -> out_valid=0 next cycle. Restart a frame from 0x00 -> first output (0x00,0x10,0x20) only after 8 accepts.
- LB_ZERO_PAD_EN defined:
  - Accept 0x00 -> column (0,0,0x00).
  - Row 1 col 3 -> (0,0x03,0x13).
  - 16 columns per frame.
